// File: rtl/tage_bank.sv
// One tagged TAGE predictor bank: registered lookup with same-cycle update forwarding,
// allocation/counter/useful updates on the previous lookup, periodic u aging and per-domain flush.
package tage_pkg;
  typedef logic [1:0] domain_t;
  localparam domain_t DOM_INIT = 2'd0;
endpackage

module tage_bank
  import tage_pkg::*;
#(
  parameter int IDX_W           = 8,
  parameter int TAG_W           = 9,
  parameter int CTR_W           = 3,
  parameter int U_W             = 2,
  parameter int TARG_W          = 32,
  parameter int AGE_PERIOD_LOG2 = 18
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  hash_idx_i,
  input  logic [TAG_W-1:0]  hash_tag_i,
  input  domain_t           domain_i,
  input  logic [TARG_W-1:0] targ_i,
  input  logic              br_result_i,
  input  logic              provider_i,
  input  logic              update_u_i,
  input  logic              dec_u_i,
  input  logic              alloc_i,
  input  logic              flush_i,
  input  domain_t           flush_dom_i,
  output logic              prediction_o,
  output logic              tag_hit_o,
  output logic [U_W-1:0]    u_o,
  output logic [TARG_W-1:0] targ_o,
  output logic              new_entry_o,
  output logic              busy_o
);
  localparam int DEPTH = 2**IDX_W;
  localparam int AC_W  = (U_W > 1) ? $clog2(U_W) : 1;
  localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};

  function automatic logic [CTR_W-1:0] ctr_sat_step(input logic [CTR_W-1:0] c, input logic up);
    if (up) return (&c) ? c : c + CTR_W'(1);
    else    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [U_W-1:0] u_sat_step(input logic [U_W-1:0] u, input logic up);
    if (up) return (&u) ? u : u + U_W'(1);
    else    return (u == '0) ? u : u - U_W'(1);
  endfunction

  typedef enum logic {S_IDLE, S_SWEEP} state_t;
  state_t state_q, state_d;

  logic [CTR_W-1:0]  ctr_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [U_W-1:0]    u_q    [DEPTH];
  logic [TARG_W-1:0] targ_q [DEPTH];
  domain_t           dom_q  [DEPTH];

  logic [IDX_W-1:0]  prev_idx_q;
  logic [TAG_W-1:0]  prev_tag_q;
  logic [TARG_W-1:0] prev_targ_q;
  domain_t           prev_dom_q;
  logic [AGE_PERIOD_LOG2-1:0] age_cnt_q;
  logic [AC_W-1:0]   age_col_q;
  logic [IDX_W-1:0]  sweep_ptr_q;
  domain_t           flush_dom_q;

  logic              idle, upd_en, age_fire, sweep_clr, fwd;
  logic [CTR_W-1:0]  old_ctr, ctr_nxt, rd_ctr;
  logic [U_W-1:0]    old_u, u_nxt, rd_u;
  logic [TAG_W-1:0]  tag_nxt, rd_tag;
  logic [TARG_W-1:0] targ_nxt, rd_targ;
  domain_t           dom_nxt, rd_dom;

  logic              pred_p1, hit_p1;
  logic [U_W-1:0]    u_p1;
  logic [TARG_W-1:0] targ_p1;

  assign idle      = (state_q == S_IDLE);
  assign upd_en    = idle && (alloc_i || provider_i || dec_u_i);
  assign age_fire  = &age_cnt_q;
  assign sweep_clr = !idle && (dom_q[sweep_ptr_q] == flush_dom_q);
  assign old_ctr   = ctr_q[prev_idx_q];
  assign old_u     = u_q[prev_idx_q];
  assign fwd       = upd_en && (hash_idx_i == prev_idx_q);

  // Post-update view of entry prev_idx; the aging clear wins over any u update on its bit.
  always_comb begin
    ctr_nxt  = old_ctr;
    u_nxt    = old_u;
    tag_nxt  = tag_q[prev_idx_q];
    targ_nxt = targ_q[prev_idx_q];
    dom_nxt  = dom_q[prev_idx_q];
    if (alloc_i) begin
      ctr_nxt  = br_result_i ? CTR_WT : CTR_WNT;
      u_nxt    = '0;
      tag_nxt  = prev_tag_q;
      targ_nxt = prev_targ_q;
      dom_nxt  = prev_dom_q;
    end else begin
      if (provider_i)
        ctr_nxt = ctr_sat_step(old_ctr, br_result_i);
      if (provider_i && update_u_i)
        u_nxt = u_sat_step(old_u, br_result_i == old_ctr[CTR_W-1]);
      else if (dec_u_i)
        u_nxt = u_sat_step(old_u, 1'b0);
    end
    if (age_fire)
      u_nxt[age_col_q] = 1'b0;
  end

  always_comb begin
    rd_ctr  = fwd ? ctr_nxt  : ctr_q[hash_idx_i];
    rd_u    = fwd ? u_nxt    : u_q[hash_idx_i];
    rd_tag  = fwd ? tag_nxt  : tag_q[hash_idx_i];
    rd_targ = fwd ? targ_nxt : targ_q[hash_idx_i];
    rd_dom  = fwd ? dom_nxt  : dom_q[hash_idx_i];
    if (age_fire)
      rd_u[age_col_q] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i]  <= '0;
        tag_q[i]  <= '0;
        u_q[i]    <= '0;
        targ_q[i] <= '0;
        dom_q[i]  <= DOM_INIT;
      end
    end else begin
      if (age_fire)
        for (int i = 0; i < DEPTH; i++) u_q[i][age_col_q] <= 1'b0;
      if (upd_en) begin
        ctr_q[prev_idx_q]  <= ctr_nxt;
        u_q[prev_idx_q]    <= u_nxt;
        tag_q[prev_idx_q]  <= tag_nxt;
        targ_q[prev_idx_q] <= targ_nxt;
        dom_q[prev_idx_q]  <= dom_nxt;
      end
      if (sweep_clr) begin
        dom_q[sweep_ptr_q] <= DOM_INIT;
        u_q[sweep_ptr_q]   <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_idx_q  <= '0;
      prev_tag_q  <= '0;
      prev_targ_q <= '0;
      prev_dom_q  <= DOM_INIT;
      age_cnt_q   <= '0;
      age_col_q   <= '0;
      sweep_ptr_q <= '0;
      flush_dom_q <= DOM_INIT;
    end else begin
      age_cnt_q <= age_cnt_q + AGE_PERIOD_LOG2'(1);
      if (age_fire)
        age_col_q <= (age_col_q == AC_W'(U_W-1)) ? '0 : age_col_q + AC_W'(1);
      if (idle) begin
        prev_idx_q  <= hash_idx_i;
        prev_tag_q  <= hash_tag_i;
        prev_targ_q <= targ_i;
        prev_dom_q  <= domain_i;
        if (flush_i) begin
          sweep_ptr_q <= '0;
          flush_dom_q <= flush_dom_i;
        end
      end else begin
        sweep_ptr_q <= sweep_ptr_q + IDX_W'(1);
      end
    end
  end

  // Stage p1: registered lookup result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_p1 <= 1'b0;
      hit_p1  <= 1'b0;
      u_p1    <= '0;
      targ_p1 <= '0;
    end else begin
      pred_p1 <= rd_ctr[CTR_W-1];
      hit_p1  <= idle && (rd_tag == hash_tag_i) && (rd_dom == domain_i);
      u_p1    <= rd_u;
      targ_p1 <= rd_targ;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (flush_i) state_d = S_SWEEP;
      S_SWEEP: if (&sweep_ptr_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == S_SWEEP);
  end

  assign prediction_o = pred_p1;
  assign tag_hit_o    = hit_p1;
  assign u_o          = u_p1;
  assign targ_o       = targ_p1;
  assign new_entry_o  = ((old_ctr == CTR_WT) || (old_ctr == CTR_WNT)) && (old_u == '0);
endmodule

// File: doc/tage_bank.md
TAGE_BANK -- requirements
Module: tage_bank

Interface
REQ-001 SHALL have parameter IDX_W, default 8: table index width; DEPTH = 2**IDX_W entries.
REQ-002 SHALL have parameter TAG_W, default 9: tag width.
REQ-003 SHALL have parameter CTR_W, default 3, legal 2..4: prediction counter width.
REQ-004 SHALL have parameter U_W, default 2: useful counter width.
REQ-005 SHALL have parameter TARG_W, default 32: target address width.
REQ-006 SHALL have parameter AGE_PERIOD_LOG2, default 18: useful-aging interval is 2**AGE_PERIOD_LOG2 cycles.
REQ-007 SHALL have ports: clk_i in 1, clock; rst_i in 1, reset. One clock; reset is synchronous and active-high.
REQ-008 SHALL have lookup ports: hash_idx_i in IDX_W; hash_tag_i in TAG_W; domain_i in domain_t; targ_i in TARG_W (target recorded on allocation).
REQ-009 SHALL have update ports, all in 1: br_result_i (resolved outcome), provider_i, update_u_i, dec_u_i, alloc_i.
REQ-010 SHALL have flush ports: flush_i in 1, start domain flush; flush_dom_i in domain_t, domain to invalidate.
REQ-011 SHALL have outputs: prediction_o 1; tag_hit_o 1; u_o U_W; targ_o TARG_W; new_entry_o 1; busy_o 1 (flush sweep active).

Function
REQ-012 SHALL hold per entry: ctr (CTR_W), tag (TAG_W), u (U_W), targ (TARG_W), dom (domain_t).
REQ-013 SHALL register lookup with 1-cycle latency: on cycle N+1, prediction_o = ctr MSB, tag_hit_o = (tag == hash_tag_i) AND (dom == domain_i), u_o, targ_o from entry hash_idx_i sampled at N.
REQ-014 SHALL register prev_idx, prev_tag, prev_targ, prev_dom each non-sweep cycle; all update inputs at cycle N+1 target entry prev_idx.
REQ-015 SHALL on alloc_i: ctr = WT (2**(CTR_W-1)) if br_result_i else WNT (WT-1); tag = prev_tag; u = 0; targ = prev_targ; dom = prev_dom.
REQ-016 SHALL on provider_i without alloc_i: saturating ctr increment if br_result_i, else saturating decrement; no update-skip when prev_idx == hash_idx_i.
REQ-017 SHALL resolve u priority: alloc_i (u=0) > provider_i with update_u_i (saturating +1 if br_result_i == old ctr MSB, else saturating -1) > dec_u_i (saturating -1).
REQ-018 SHALL drive new_entry_o combinationally: 1 when ctr[prev_idx] is WT or WNT and u[prev_idx] == 0.
REQ-019 SHALL forward: when hash_idx_i == prev_idx and an update writes that entry in the same cycle, the registered lookup returns the post-update values.
REQ-020 SHALL age useful bits: free-running AGE_PERIOD_LOG2-bit counter; on all-ones, clear bit age_col of u in every one of DEPTH entries, toggle age_col (rotating 0..U_W-1), wrap counter to 0; the clear overrides any same-cycle u update on that bit.
REQ-021 SHALL implement FSM IDLE/SWEEP: IDLE + flush_i -> SWEEP, latch flush_dom_i, sweep_ptr = 0; SWEEP visits one entry per cycle, setting dom = INIT and u = 0 where dom == latched domain; at sweep_ptr == DEPTH-1 -> IDLE.
REQ-022 SHALL in SWEEP drive busy_o = 1, force tag_hit_o = 0, ignore alloc_i/provider_i/dec_u_i/update_u_i and flush_i; the aging counter keeps running.
REQ-023 SHALL on flush_i in the same cycle as updates in IDLE apply the updates first, then enter SWEEP next cycle.

Reset
REQ-024 SHALL on rst_i clear every entry (ctr, tag, u, targ = 0; dom = INIT), the aging counter, age_col, sweep_ptr and prev_* (domain INIT), and set FSM = IDLE.
REQ-025 SHALL hold prediction_o, tag_hit_o, u_o, targ_o, busy_o at 0 the cycle after rst_i is sampled; rst_i mid-SWEEP aborts the sweep.

Verification
REQ-026 Reset, lookup idx 5 tag 0 domain INIT -> tag_hit_o = 1, prediction_o = 0, u_o = 0, targ_o = 0.
REQ-027 Lookup idx 5 tag 0x1A targ 0x1000, then alloc_i, br_result_i = 1 -> ctr[5] = 4, re-lookup gives tag_hit_o = 1, prediction_o = 1, targ_o = 0x1000.
REQ-028 Lookup idx 3 back-to-back with provider_i, br_result_i = 0 on ctr = 4 -> second lookup prediction_o = 0 (forwarded ctr = 3).
REQ-029 AGE_PERIOD_LOG2 = 4, u[0] = u[DEPTH-1] = 3 -> after 16 cycles both = 2, after 32 cycles both = 0.
REQ-030 Allocate idx 2 domain A, idx 7 domain B; flush_i with A -> busy_o high DEPTH cycles; lookups ignored in sweep; afterwards idx 2 misses for A, idx 7 still hits for B.
REQ-031 Provider at ctr = 7 with br_result_i = 1 and at ctr = 0 with br_result_i = 0 -> ctr saturates; update_u_i at u = 3 correct holds 3.
